// File: rtl/iter_arith_cmp.sv
// iter_arith_cmp
//   Iterative magnitude comparator. Compares two NBITS-wide operands NDIGIT
//   bits per cycle, MSB-first, and stops at the first differing digit.
//   Signed mode flips the sign bit of both operands at capture so that an
//   unsigned digit-serial compare yields the two's-complement ordering.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   in_val   in   request valid
//   in_rdy   out  ready to accept a request (IDLE)
//   in0/in1  in   operands, NBITS wide
//   sign     in   1 = signed compare, 0 = unsigned
//   out_val  out  result valid (DONE)
//   out_rdy  in   consumer accepts result
//   lt/eq/gt out  one-hot result, held while out_val is high
//
// State | Meaning
// IDLE  | waiting for a request, in_rdy high
// CALC  | comparing one digit per cycle
// DONE  | result presented, waiting for out_rdy
module iter_arith_cmp #(
    parameter int NBITS  = 16,
    parameter int NDIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic             sign,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NDIG = NBITS / NDIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NBITS-1:0]  r_a;
    logic [NBITS-1:0]  r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_lt;
    logic              r_eq;
    logic              r_gt;

    logic [NDIGIT-1:0] w_dig_a;
    logic [NDIGIT-1:0] w_dig_b;
    logic              w_diff;
    logic              w_last;

    // Operands are shifted left after each equal digit, so the digit under
    // test is always the top NDIGIT bits of the working registers.
    assign w_dig_a = r_a[NBITS-1 -: NDIGIT];
    assign w_dig_b = r_b[NBITS-1 -: NDIGIT];
    assign w_diff  = (w_dig_a != w_dig_b);
    assign w_last  = (r_cnt == LAST_DIG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_diff || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_val) begin
                        r_a   <= {in0[NBITS-1] ^ sign, in0[NBITS-2:0]};
                        r_b   <= {in1[NBITS-1] ^ sign, in1[NBITS-2:0]};
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    if (w_diff) begin
                        r_lt <= (w_dig_a < w_dig_b);
                        r_gt <= (w_dig_a > w_dig_b);
                    end else if (w_last) begin
                        r_eq <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_a   <= r_a << NDIGIT;
                        r_b   <= r_b << NDIGIT;
                    end
                end
                S_DONE: begin
                    if (out_rdy) begin
                        r_lt <= 1'b0;
                        r_eq <= 1'b0;
                        r_gt <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign lt = r_lt;
    assign eq = r_eq;
    assign gt = r_gt;

endmodule

// File: tb/tb_iter_arith_cmp.sv
module tb_iter_arith_cmp;

    localparam int NB   = 16;
    localparam int ND   = 4;
    localparam int NDIG = NB / ND;

    logic          clk;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in0;
    logic [NB-1:0] in1;
    logic          sign;
    logic          out_val;
    logic          out_rdy;
    logic          lt;
    logic          eq;
    logic          gt;

    iter_arith_cmp #(.NBITS(NB), .NDIGIT(ND)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .sign    (sign),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .lt      (lt),
        .eq      (eq),
        .gt      (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        int   k;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    int cyc     = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int rel_cnt = 0;
    int rel_cyc = 0;
    bit rel_flag = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer ordering; k = first differing digit + 1.
    function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s);
        exp_t   r;
        longint va;
        longint vb;
        longint x;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[NB-1]) va = va - (longint'(1) << NB);
        if (s && b[NB-1]) vb = vb - (longint'(1) << NB);
        r.lt = (va < vb);
        r.eq = (va == vb);
        r.gt = (va > vb);
        r.k  = NDIG;
        x = longint'(a ^ b);
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (((x >> (NB - (i + 1) * ND)) & ((longint'(1) << ND) - 1)) != 0) r.k = i + 1;
        end
        return r;
    endfunction

    // Edge observer: counts cycles, accepts and releases as seen by the DUT.
    always @(posedge clk) begin
        cyc++;
        if (!reset && in_val && in_rdy) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (!reset && out_val && out_rdy) begin
            rel_cnt++;
            rel_cyc = cyc;
            rel_flag = 1;
        end
    end

    // Monitor: pops the scoreboard on each new result.
    exp_t cur;
    bit   busy = 0;
    always @(negedge clk) begin
        if (reset) begin
            busy = 0;
            rel_flag = 0;
        end else begin
            if (rel_flag) begin
                rel_flag = 0;
                chk("release_out_val", 32'(out_val), 32'd0);
                chk("release_in_rdy", 32'(in_rdy), 32'd1);
            end
            if (out_val) begin
                if (!busy) begin
                    busy = 1;
                    if (sb.size() == 0) begin
                        chk("unexpected_out_val", 32'(out_val), 32'd0);
                        cur = '0;
                    end else begin
                        cur = sb.pop_front();
                        chk("result_flags", 32'({lt, eq, gt}), 32'({cur.lt, cur.eq, cur.gt}));
                        chk("latency_k", 32'(cyc - acc_cyc), 32'(cur.k));
                        chk("done_in_rdy", 32'(in_rdy), 32'd0);
                    end
                end else begin
                    chk("hold_flags", 32'({lt, eq, gt}), 32'({cur.lt, cur.eq, cur.gt}));
                    chk("hold_in_rdy", 32'(in_rdy), 32'd0);
                end
            end else begin
                busy = 0;
            end
        end
    end

    task automatic start_tx(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s,
                            input bit scramble);
        int n;
        bit ok;
        sb.push_back(model(a, b, s));
        in0 = a;
        in1 = b;
        sign = s;
        in_val = 1'b1;
        n = acc_cnt;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_cnt != n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        in_val = 1'b0;
        if (scramble) begin
            in0 = '0;
            in1 = NB'($urandom);
            sign = ~s;
        end
    endtask

    task automatic finish_tx(input int hold);
        bit ok;
        ok = out_val;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (out_val) ok = 1;
        end
        if (!ok) begin
            chk("result_timeout", 32'd0, 32'd1);
        end else if (!out_rdy) begin
            repeat (hold) @(negedge clk);
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic do_tx(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s,
                         input bit scramble, input int hold);
        start_tx(a, b, s, scramble);
        finish_tx(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        int mode;

        reset = 1'b1;
        in_val = 1'b1;
        in0 = 16'h1111;
        in1 = 16'h2222;
        sign = 1'b0;
        out_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_in_rdy", 32'(in_rdy), 32'd1);
            chk("reset_out_val", 32'(out_val), 32'd0);
            chk("reset_flags", 32'({lt, eq, gt}), 32'd0);
        end
        chk("reset_no_accept", 32'(acc_cnt), 32'd0);
        in_val = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Directed, out_rdy held high.
        out_rdy = 1'b1;
        do_tx(16'h1234, 16'h1235, 1'b0, 0, 0);
        do_tx(16'h8000, 16'h0001, 1'b0, 0, 0);
        do_tx(16'h8000, 16'h0001, 1'b1, 0, 0);
        do_tx(16'hFFFF, 16'hFFFB, 1'b1, 0, 0);
        do_tx(16'h0000, 16'hFF80, 1'b1, 0, 0);
        do_tx(16'hA5A5, 16'hA5A5, 1'b0, 1, 0);
        do_tx(16'hA5A5, 16'hA5A5, 1'b1, 1, 0);

        // Backpressure: result held, new request waits.
        out_rdy = 1'b0;
        start_tx(16'h0F00, 16'h0E00, 1'b0, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_val) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("bp_result_timeout", 32'd0, 32'd1);
        sb.push_back(model(16'h0003, 16'h0007, 1'b0));
        in0 = 16'h0003;
        in1 = 16'h0007;
        sign = 1'b0;
        in_val = 1'b1;
        n = acc_cnt;
        repeat (5) @(negedge clk);
        chk("bp_no_accept", 32'(acc_cnt), 32'(n));
        chk("bp_out_val", 32'(out_val), 32'd1);
        out_rdy = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt != n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("bp_accept_timeout", 32'd0, 32'd1);
        chk("bp_accept_edge", 32'(acc_cyc), 32'(rel_cyc + 1));
        in_val = 1'b0;
        finish_tx(0);

        // Reset in the middle of CALC.
        start_tx(16'h1234, 16'h1235, 1'b0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midreset_in_rdy", 32'(in_rdy), 32'd1);
        chk("midreset_out_val", 32'(out_val), 32'd0);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midreset_quiet", 32'(out_val), 32'd0);
        end
        do_tx(16'h0002, 16'h0001, 1'b0, 0, 0);

        // Randomized traffic with random result backpressure.
        out_rdy = 1'b0;
        for (int t = 0; t < 40; t++) begin
            a = NB'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: b = NB'($urandom);
                1: b = a;
                2: b = a ^ (NB'(1) << $urandom_range(0, NB - 1));
                default: b = a ^ NB'($urandom_range(0, 15));
            endcase
            do_tx(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_arith_cmp.md
# iter_arith_cmp

Parametrised, iterative magnitude comparator for NBITS-wide operands in signed or unsigned mode. It examines NDIGIT bits per cycle, MSB-first, and terminates early at the first differing digit. Operands and results move over val/rdy handshakes. It sits in the arithmetic library next to the combinational fixed-width comparators, and is used where a full-width single-cycle compare is too costly.

## Interface
- NBITS, default 16: operand width; NBITS >= 2; NBITS % NDIGIT == 0.
- NDIGIT, default 4: bits examined per cycle; 1 <= NDIGIT <= NBITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  request valid.
- in_rdy  output  1  block can accept a request.
- in0  input  NBITS  first operand.
- in1  input  NBITS  second operand.
- sign  input  1  1 = two's-complement compare; 0 = unsigned compare.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- lt  output  1  in0 < in1.
- eq  output  1  in0 == in1.
- gt  output  1  in0 > in1.

## Operation
- **FSM states:** IDLE, CALC, DONE. Reset forces IDLE.
- **IDLE**
  - in_rdy=1, out_val=0, lt/eq/gt=0.
  - On in_val && in_rdy at a clock edge: latch in0, in1 and sign; clear digit counter; go to CALC.
- **Signed mode:** at capture, invert bit NBITS-1 of both latched operands. An unsigned compare of the modified values then gives the signed result.
- **CALC**
  - in_rdy=0, out_val=0.
  - Digit i (bits NBITS-1-i*NDIGIT down to NBITS-(i+1)*NDIGIT) is compared in cycle i after capture.
  - If the digits differ: record lt/gt from the digit compare, go to DONE.
  - Else if i == NBITS/NDIGIT-1: record eq, go to DONE.
  - Else: increment counter, stay in CALC.
- **DONE**
  - out_val=1; exactly one of lt/eq/gt is 1, held stable.
  - in_rdy=0; in_val is ignored.
  - On out_rdy: go to IDLE and clear the flags.
- **Non-interleaving:** one transaction in flight; no overlap of accept and result.
- **Operand isolation:** in0/in1/sign changes after capture have no effect on the result.
- **Outputs:** all outputs are registered or decoded from state only. There is no combinational path from in_val/out_rdy to any output.

## Timing
- **Reset values:** state=IDLE, in_rdy=1, out_val=0, lt=eq=gt=0, counter=0.
- **Accept edge:** E0 (in_val && in_rdy sampled high).
- **Latency:**
  - out_val rises in the cycle after edge E_k, where k = (index of first differing digit)+1, range 1..NBITS/NDIGIT.
  - Equal operands: k = NBITS/NDIGIT.
- **Result release:** out_val && out_rdy at edge E_r gives IDLE after E_r. in_rdy=1 in the following cycle, so the next accept is at the earliest E_r+1.
- **Minimum transaction period:** k+2 cycles with out_rdy held high.
- **Backpressure:** out_rdy low holds DONE indefinitely with out_val and flags unchanged.
- **Reset mid-operation** (CALC or DONE):
  - Immediate return to IDLE.
  - In-flight result discarded; no out_val pulse.
- **NDIGIT == NBITS:** k=1 always; single-cycle CALC.

## Test plan
- **Reset:** assert reset for 2 cycles with in_val=1 → in_rdy=1, out_val=0, lt=eq=gt=0. No accept while reset is high.
- **Unsigned (NBITS=16, NDIGIT=4, sign=0):**
  - in0=0x1234, in1=0x1235 → lt=1, out_val in cycle after E4 (k=4).
  - in0=0x8000, in1=0x0001 → gt=1, k=1.
- **Signed (sign=1):**
  - in0=0x8000, in1=0x0001 → lt=1, k=1.
  - in0=0xFFFF, in1=0xFFFB (-1 vs -5) → gt=1, k=4.
  - in0=0x0000, in1=0xFF80 → gt=1, k=1.
- **Equality and isolation:** in0=in1=0xA5A5 in both modes → eq=1, k=4. Changing in0 to 0x0000 after E0 must not alter the result.
- **Backpressure:**
  - Result ready with out_rdy=0 for 5 cycles, in_val=1 with new operands → out_val and flags held, in_rdy=0, nothing accepted.
  - out_rdy=1 → out_val=0 next cycle, in_rdy=1, new request accepted on the following edge.
- **Reset mid-CALC:** accept 0x1234 vs 0x1235, assert reset after E2 → out_val never asserts, in_rdy=1. A fresh 0x0002 vs 0x0001 request then completes with gt=1, k=4.
